dff_debounce_sync: RTL and testbench

- Front-end conditioning stage that sits directly upstream of the plain D flip-flop stage.
- Takes a raw asynchronous, bouncy input `d` and brings it into the `clk` domain through a 2-flop synchronizer.
- Filters it with a counter-based debounce state machine and produces a clean level `q` plus single-cycle `rise`/`fall` strobes for downstream registers.
- Every output is registered and glitch-free.

---
 rtl/dff_debounce_sync.sv | 126 ++++++++++++
 tb/tb_dff_debounce_sync.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dff_debounce_sync.sv
// Debounce front end: 2-flop synchronizer, then a counter-qualified level FSM.
// Drives a clean level `q` plus one-cycle `rise`/`fall` strobes. Every output is registered.
module dff_debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        S_LOW,
        S_TO_HIGH,
        S_HIGH,
        S_TO_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam bit               SINGLE   = (STABLE_CYCLES == 1);

    logic             sync1, sync2;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             rise_next, fall_next, q_next, busy_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            S_LOW: begin
                cnt_next = '0;
                if (sync2) begin
                    if (SINGLE) begin
                        state_next = S_HIGH;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = S_TO_HIGH;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            S_TO_HIGH: begin
                if (!sync2) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                cnt_next = '0;
                if (!sync2) begin
                    if (SINGLE) begin
                        state_next = S_LOW;
                        fall_next  = 1'b1;
                    end else begin
                        state_next = S_TO_LOW;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            S_TO_LOW: begin
                if (sync2) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = S_LOW;
                cnt_next   = '0;
            end
        endcase
        // Level outputs follow the state being entered, so they move on the same edge as state.
        q_next    = (state_next == S_HIGH) || (state_next == S_TO_LOW);
        busy_next = (state_next == S_TO_HIGH) || (state_next == S_TO_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            q     <= q_next;
            rise  <= rise_next;
            fall  <= fall_next;
            busy  <= busy_next;
        end
    end

endmodule

// File: tb/tb_dff_debounce_sync.sv
// Bench for dff_debounce_sync: directed scenarios and random bursts, checked against a
// run-length model of the synchronized input (q flips after SC consecutive opposite samples).
module tb_dff_debounce_sync;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic d;
    logic q, rise, fall, busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic m_s1, m_s2, m_q, m_rise, m_fall;
    int   m_run;

    logic [3:0] step_tbl [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                  4'b0001, 4'b1100, 4'b1000, 4'b1000};
    logic [3:0] fall_tbl [8] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001,
                                  4'b1001, 4'b0010, 4'b0000, 4'b0000};

    always #5 clk = ~clk;

    dff_debounce_sync #(
        .STABLE_CYCLES(SC),
        .CNT_W        (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed {q,rise,fall,busy}=%b expected %b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_q = 1'b0;
        m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    endfunction

    // One clock edge: the FSM sees the sample that was two flops deep before this edge.
    function automatic void model_edge(input logic dv);
        logic samp;
        samp   = m_s2;
        m_s2   = m_s1;
        m_s1   = dv;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (samp != m_q) begin
            m_run++;
            if (m_run == SC) begin
                m_q    = ~m_q;
                m_rise = m_q;
                m_fall = ~m_q;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
    endfunction

    function automatic logic [3:0] model_out();
        return {m_q, m_rise, m_fall, (m_run != 0)};
    endfunction

    function automatic logic [3:0] dut_out();
        return {q, rise, fall, busy};
    endfunction

    task automatic cycle(input logic dv, input string tag);
        d = dv;
        @(posedge clk);
        if (rst_n) model_edge(dv);
        else       model_reset();
        #1;
        check(tag, dut_out(), model_out());
    endtask

    task automatic pulse_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check(tag, dut_out(), 4'b0000);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        int first_q;
        int n_rise;
        rst_n = 1'b1;
        d     = 1'b1;
        model_reset();

        // Reset held with d=1, then released; q must rise on the 6th edge after release.
        #2 rst_n = 1'b0;
        #1 check("reset_async", dut_out(), 4'b0000);
        repeat (3) cycle(1'b1, "reset_hold");
        rst_n = 1'b1;
        #1 check("reset_release", dut_out(), 4'b0000);
        for (int i = 0; i < 6; i++) cycle(1'b1, "reset_requal");
        check("reset_rise_edge6", dut_out(), 4'b1100);
        cycle(1'b1, "reset_after");
        check("reset_rise_once", dut_out(), 4'b1000);

        repeat (10) cycle(1'b0, "settle_low");

        // Clean step, checked against a fixed timeline as well as the model.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, "clean_step");
            check("clean_step_tbl", dut_out(), step_tbl[i]);
        end

        // Falling edge from q=1.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, "falling");
            check("falling_tbl", dut_out(), fall_tbl[i]);
        end

        // Bounce rejection: 1,1,0,1,1 then low; q must never rise.
        n_rise = 0;
        foreach (step_tbl[i]) begin
            cycle((i == 0 || i == 1 || i == 3 || i == 4), "bounce_reject");
            if (rise || q) n_rise++;
        end
        repeat (4) cycle(1'b0, "bounce_reject_tail");
        check_int("bounce_no_rise", n_rise, 0);
        check("bounce_idle", dut_out(), 4'b0000);

        // Bounce then settle: 1,0,1 then held 1; q rises 5 edges after the last 0->1 sample.
        first_q = -1;
        n_rise  = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(i != 1, "bounce_settle");
            if (q && first_q < 0) first_q = i;
            if (rise) n_rise++;
        end
        check_int("bounce_settle_edge", first_q, 7);
        check_int("bounce_settle_rises", n_rise, 1);

        repeat (10) cycle(1'b0, "settle_low2");

        // Reset mid-qualification (count at 2), then a full requalification.
        repeat (4) cycle(1'b1, "midq_pre");
        check("midq_busy", dut_out(), 4'b0001);
        pulse_reset("midq_reset");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, "midq_requal");
            check("midq_requal_tbl", dut_out(), step_tbl[i]);
        end

        // Random bursts of varying length, with occasional reset pulses.
        for (int b = 0; b < 60; b++) begin
            logic v;
            int   len;
            v   = logic'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) cycle(v, "random");
            if ($urandom_range(0, 19) == 0) pulse_reset("random_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
